uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver; next generation of the serial front end that feeds the matrix loader (size byte, then A and B elements).
- Adds the following over the current receiver:
  - runtime baud select;
  - configurable data and stop bits;
  - 3-sample majority voting;
  - framing, break and overrun detection;
  - valid/ready output handshake.

Parameters:
- CLK_FREQ, 50_000_000: system clock in Hz; used to compute the baud divisors.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: ticks per bit; must be even and at least 8.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset; asynchronous, active-high.
- rx, in, 1: serial line; idles high; asynchronous to clk.
- b_sel, in, 2: baud select. 00=4800, 01=9600, 10=19200, 11=115200.
- parity_odd, in, 1: 1=odd parity, 0=even parity. Present only with UART_RX_PARITY_EN.
- err_clr, in, 1: single-cycle pulse; clears the sticky overrun flag.
- m_data, out, DATA_BITS: received word, LSB first on the wire.
- m_valid, out, 1: m_data and the per-word error flags are valid.
- m_ready, in, 1: consumer accepts the word.
- frame_err, out, 1: stop bit sampled low for the word in m_data.
- parity_err, out, 1: parity mismatch for the word in m_data. Tied 0 without the feature.
- break_det, out, 1: one-cycle pulse; whole frame low.
- overrun, out, 1: sticky; a completed word was dropped.
- busy, out, 1: high whenever state is not IDLE.

Behaviour:
- Reset values: m_data=0; m_valid, frame_err, parity_err, break_det, overrun, busy all 0; synchroniser flops=1; state=IDLE.
- Reset mid-frame aborts the frame immediately and discards partial data.
- Input sync: rx passes through a 2-flop synchroniser; all sampling uses the synchronised signal.
- Tick generator:
  - divisor = round(CLK_FREQ / (baud * OVERSAMPLE)); at 50 MHz the divisors are 651, 326, 163 and 27.
  - Counter counts 0..div-1; tick pulses when it wraps.
  - b_sel is latched on start detection; a change of b_sel mid-frame has no effect until the next frame.
  - Tick counter restarts at 0 on start detection.
- Sampling: each bit is decided by majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM (transitions occur only on the tick at which the bit is decided, i.e. mid-bit):
  - IDLE: a 1→0 transition on synchronised rx goes to START.
  - START: majority 1 → false start, return to IDLE with no output. Majority 0 → DATA.
  - DATA: shift DATA_BITS bits in, LSB first; after the last bit go to PARITY if the feature is enabled, else STOP.
  - PARITY: compare against the parity computed over the data bits; go to STOP.
  - STOP:
    - With STOP_BITS=2, two stop bits are checked; either one low sets frame_err.
    - Data all zero, parity bit 0 (if present) and stop low → break: pulse break_det, deliver no word, go to BREAK.
    - Otherwise deliver the word and return to IDLE at mid-stop, so the receiver can resync to a back-to-back start bit.
  - BREAK: wait until synchronised rx=1, then IDLE.
- Delivery:
  - m_data, frame_err and parity_err are loaded and m_valid set 1 cycle after the deciding tick.
  - All stay stable while m_valid=1 and m_ready=0.
  - m_valid clears in the cycle after m_valid&&m_ready.
- Overrun:
  - A word completes while m_valid=1 and m_ready=0: the new word is dropped, held data is kept, overrun is set.
  - Completion in the same cycle as an acceptance: the new word is loaded, m_valid stays 1, no overrun.
  - err_clr clears overrun; err_clr in the same cycle as a new overrun leaves overrun set.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame carries one parity bit after the data; the parity_odd port exists; parity_err is computed per word.
- Undefined: no parity bit in the frame; the parity_odd port is absent; parity_err is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - the baud-select encoding constants;
  - the divisor function of (CLK_FREQ, baud, OVERSAMPLE);
  - the FSM state typedef: IDLE, START, DATA, PARITY, STOP, BREAK.
- One sub-module, uart_baud_tick: divisor latch, tick counter and restart input, reused later by the transmitter.

Test Plan:
- 9600 baud (b_sel=01), send 0x0A with m_ready=1 → m_data=0x0A, m_valid for 1 cycle, no error flags, busy falls at mid-stop.
- Drive rx low for 3 bit-ticks, then high → false start: no m_valid, state back to IDLE.
- Send 0x55 with stop bit forced low → m_data=0x55, frame_err=1; send 0x00 with stop low → break_det pulse, no m_valid, busy held until rx returns high.
- m_ready=0, send 0x55 then 0xAA → m_data=0x55, overrun=1; raise m_ready → 0x55 accepted; pulse err_clr → overrun=0.
- Switch b_sel to 11 (115200) while idle, send 0xC3 back-to-back with 0x3C → both received; toggling b_sel mid-frame → byte still correct.
- With UART_RX_PARITY_EN and parity_odd=1, send 0x07 with parity bit 1 → parity_err=1; assert rst mid-data → all outputs reset, next byte 0x12 received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select encoding, divisor helper and receiver states.
package uart_pkg;
  localparam logic [1:0] BSEL_4800   = 2'b00;
  localparam logic [1:0] BSEL_9600   = 2'b01;
  localparam logic [1:0] BSEL_19200  = 2'b10;
  localparam logic [1:0] BSEL_115200 = 2'b11;

  localparam int BAUD_4800   = 4800;
  localparam int BAUD_9600   = 9600;
  localparam int BAUD_19200  = 19200;
  localparam int BAUD_115200 = 115200;

  // Rounded clk_freq / (baud * os).
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word stream: data plus per-word error flags under valid/ready.
interface uart_rx_os_if #(parameter int DATA_BITS = 8) ();
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (output m_data, m_valid, frame_err, parity_err, input m_ready);
  modport slave  (input m_data, m_valid, frame_err, parity_err, output m_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator; divisor is latched from b_sel and the count zeroed on restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_i,
  input  logic [1:0] b_sel_i,
  output logic       tick_o
);
  localparam int CW = $clog2(baud_div(CLK_FREQ, BAUD_4800, OVERSAMPLE) + 1);
  localparam logic [CW-1:0] DIV_0 = CW'(baud_div(CLK_FREQ, BAUD_4800,   OVERSAMPLE));
  localparam logic [CW-1:0] DIV_1 = CW'(baud_div(CLK_FREQ, BAUD_9600,   OVERSAMPLE));
  localparam logic [CW-1:0] DIV_2 = CW'(baud_div(CLK_FREQ, BAUD_19200,  OVERSAMPLE));
  localparam logic [CW-1:0] DIV_3 = CW'(baud_div(CLK_FREQ, BAUD_115200, OVERSAMPLE));

  logic [CW-1:0] div_q, div_d, cnt_q, cnt_d, sel_div;
  logic          wrap;

  always_comb begin
    case (b_sel_i)
      BSEL_4800:  sel_div = DIV_0;
      BSEL_9600:  sel_div = DIV_1;
      BSEL_19200: sel_div = DIV_2;
      default:    sel_div = DIV_3;
    endcase
  end

  assign wrap   = (cnt_q == div_q - CW'(1));
  assign tick_o = wrap & ~restart_i;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q + CW'(1);
    if (restart_i) begin
      div_d = sel_div;
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote, framing/break/overrun, valid/ready out.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic [1:0]   b_sel,
`ifdef UART_RX_PARITY_EN
  input  logic         parity_odd,
`endif
  input  logic         err_clr,
  uart_rx_os_if.master m_if,
  output logic         break_det,
  output logic         overrun,
  output logic         busy
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] SMP_A   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] SMP_B   = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] SMP_C   = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif

  state_e               state_q, state_d;
  logic                 rx_s1_q, rx_s2_q, rx_d_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic                 stop_cnt_q, smp_a_q, smp_b_q;
  logic [DATA_BITS-1:0] shift_q, data_q, data_d;
  logic                 ferr_q, par_bit_q, perr_q;
  logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, brk_q, ovr_q, ovr_d;
  logic                 tick, start_det, decide, maj, last_stop, stop_low, is_break;
  logic                 word_done, brk_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_d_q  <= rx_s2_q;
    end
  end

  assign start_det = (state_q == IDLE) & rx_d_q & ~rx_s2_q;

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (start_det),
    .b_sel_i   (b_sel),
    .tick_o    (tick)
  );

  // Third sample completes the vote; every FSM move except IDLE/BREAK exits happens here.
  assign decide    = tick & (os_cnt_q == SMP_C) & (state_q != IDLE) & (state_q != BREAK);
  assign maj       = (smp_a_q & smp_b_q) | (smp_a_q & rx_s2_q) | (smp_b_q & rx_s2_q);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;
  assign stop_low  = ferr_q | ~maj;
  assign is_break  = ~|shift_q & ~par_bit_q & stop_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_det) state_d = START;
      START:  if (decide) state_d = maj ? IDLE : DATA;
      DATA:   if (decide && bit_cnt_q == BIT_LAST) state_d = AFTER_DATA;
      PARITY: if (decide) state_d = STOP;
      STOP:   if (decide && last_stop) state_d = is_break ? BREAK : IDLE;
      BREAK:  if (rx_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    word_done = decide & (state_q == STOP) & last_stop & ~is_break;
    brk_ev    = decide & (state_q == STOP) & last_stop & is_break;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      smp_a_q    <= 1'b1;
      smp_b_q    <= 1'b1;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else if (start_det) begin
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else if (tick) begin
      os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
      if (os_cnt_q == SMP_A) smp_a_q <= rx_s2_q;
      if (os_cnt_q == SMP_B) smp_b_q <= rx_s2_q;
      if (decide) begin
        case (state_q)
          DATA: begin
            shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            par_bit_q <= maj;
            perr_q    <= maj ^ (^shift_q) ^ parity_odd;
          end
`endif
          STOP: begin
            ferr_q     <= stop_low;
            stop_cnt_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A word arriving while the held one is unaccepted is dropped and flagged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = ovr_q & ~err_clr;
    if (valid_q && m_if.m_ready) valid_d = 1'b0;
    if (word_done) begin
      if (!valid_q || m_if.m_ready) begin
        data_d  = shift_q;
        fe_d    = stop_low;
        pe_d    = perr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      brk_q   <= brk_ev;
      ovr_q   <= ovr_d;
    end
  end

  assign m_if.m_data     = data_q;
  assign m_if.m_valid    = valid_q;
  assign m_if.frame_err  = fe_q;
  assign m_if.parity_err = pe_q;
  assign break_det       = brk_q;
  assign overrun         = ovr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at a reduced clock so every baud rate fits a short run.
module tb_uart_rx_os;
  localparam int CLK_FREQ = 1_843_200;
  localparam int DB       = 8;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, err_clr = 1'b0;
  logic [1:0] b_sel = 2'b01;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
`endif
  logic       break_det, overrun, busy;
  int         checks = 0, failures = 0;
  int         div_tb = 12, bit_cyc = 192;
  int         valid_cycles = 0, break_cnt = 0;
  logic [9:0] rxq[$];
  logic       bm, bl, bh;

  uart_rx_os_if #(.DATA_BITS(DB)) s_if ();

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(DB), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .b_sel     (b_sel),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .err_clr   (err_clr),
    .m_if      (s_if),
    .break_det (break_det),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_if.m_valid) valid_cycles++;
    if (s_if.m_valid && s_if.m_ready) rxq.push_back({s_if.parity_err, s_if.frame_err, s_if.m_data});
    if (break_det) break_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hand-computed divisors for 1.8432 MHz / 16x oversampling.
  task automatic set_baud(input logic [1:0] s);
    b_sel = s;
    case (s)
      2'b00:   div_tb = 24;
      2'b01:   div_tb = 12;
      2'b10:   div_tb = 6;
      default: div_tb = 1;
    endcase
    bit_cyc = 16 * div_tb;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                            input int extra_low, output logic b_mid, output logic b_late,
                            output logic b_hold);
    rx = 1'b0;
    cyc(bit_cyc);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      cyc(bit_cyc);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_v;
    cyc(bit_cyc);
`endif
    rx = stop_v;
    cyc(8 * div_tb);
    b_mid = busy;
    cyc(4 * div_tb);
    b_late = busy;
    cyc(4 * div_tb);
    if (extra_low > 0) cyc(extra_low);
    b_hold = busy;
    rx = 1'b1;
  endtask

  task automatic pop_word(output logic [9:0] e);
    if (rxq.size() > 0) e = rxq.pop_front();
    else e = 10'h3FF;
  endtask

  task automatic test_pkg();
    int got;
    got = uart_pkg::baud_div(50_000_000, 4800, 16);
    checks++; if (got !== 651) begin failures++; $display("FAIL div_4800: got %0d expected 651", got); end
    got = uart_pkg::baud_div(50_000_000, 9600, 16);
    checks++; if (got !== 326) begin failures++; $display("FAIL div_9600: got %0d expected 326", got); end
    got = uart_pkg::baud_div(50_000_000, 19200, 16);
    checks++; if (got !== 163) begin failures++; $display("FAIL div_19200: got %0d expected 163", got); end
    got = uart_pkg::baud_div(50_000_000, 115200, 16);
    checks++; if (got !== 27) begin failures++; $display("FAIL div_115200: got %0d expected 27", got); end
  endtask

  task automatic test_reset();
    rx = 1'b0;
    cyc(4);
    checks++; if (s_if.m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data: got %0h expected 0", s_if.m_data); end
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %b expected 0", s_if.m_valid); end
    checks++; if (s_if.frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err: got %b expected 0", s_if.frame_err); end
    checks++; if (s_if.parity_err !== 1'b0) begin failures++; $display("FAIL rst_parity_err: got %b expected 0", s_if.parity_err); end
    checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL rst_break_det: got %b expected 0", break_det); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rx = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(8);
  endtask

  task automatic test_basic();
    int v0;
    logic [9:0] e;
    set_baud(2'b01);
    s_if.m_ready = 1'b1;
    rxq.delete();
    v0 = valid_cycles;
    send_frame(8'h0A, 1'b1, 1'b0, 0, bm, bl, bh);
    cyc(bit_cyc);
    checks++; if (bm !== 1'b1) begin failures++; $display("FAIL basic_busy_early_stop: got %b expected 1", bm); end
    checks++; if (bl !== 1'b0) begin failures++; $display("FAIL basic_busy_after_midstop: got %b expected 0", bl); end
    checks++; if (rxq.size() != 1) begin failures++; $display("FAIL basic_count: got %0d expected 1", rxq.size()); end
    pop_word(e);
    checks++; if (e[7:0] !== 8'h0A) begin failures++; $display("FAIL basic_data: got %0h expected 0a", e[7:0]); end
    checks++; if (e[9:8] !== 2'b00) begin failures++; $display("FAIL basic_flags: got %b expected 00", e[9:8]); end
    checks++; if (valid_cycles - v0 != 1) begin failures++; $display("FAIL basic_valid_len: got %0d expected 1", valid_cycles - v0); end
  endtask

  task automatic test_false_start();
    int v0;
    rxq.delete();
    v0 = valid_cycles;
    rx = 1'b0;
    cyc(2 * div_tb);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fs_busy_start: got %b expected 1", busy); end
    cyc(div_tb);
    rx = 1'b1;
    cyc(2 * bit_cyc);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fs_idle: got %b expected 0", busy); end
    checks++; if (valid_cycles != v0) begin failures++; $display("FAIL fs_no_valid: got %0d expected %0d", valid_cycles, v0); end
  endtask

  task automatic test_frame_err();
    int b0;
    logic [9:0] e;
    rxq.delete();
    b0 = break_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 0, bm, bl, bh);
    cyc(bit_cyc);
    checks++; if (rxq.size() != 1) begin failures++; $display("FAIL fe_count: got %0d expected 1", rxq.size()); end
    pop_word(e);
    checks++; if (e[7:0] !== 8'h55) begin failures++; $display("FAIL fe_data: got %0h expected 55", e[7:0]); end
    checks++; if (e[8] !== 1'b1) begin failures++; $display("FAIL fe_flag: got %b expected 1", e[8]); end
    checks++; if (break_cnt != b0) begin failures++; $display("FAIL fe_no_break: got %0d expected %0d", break_cnt, b0); end
  endtask

  task automatic test_break();
    int b0, v0;
    b0 = break_cnt;
    v0 = valid_cycles;
    send_frame(8'h00, 1'b0, 1'b0, 2 * bit_cyc, bm, bl, bh);
    cyc(6);
    checks++; if (break_cnt != b0 + 1) begin failures++; $display("FAIL brk_pulse: got %0d expected %0d", break_cnt, b0 + 1); end
    checks++; if (valid_cycles != v0) begin failures++; $display("FAIL brk_no_word: got %0d expected %0d", valid_cycles, v0); end
    checks++; if (bh !== 1'b1) begin failures++; $display("FAIL brk_busy_hold: got %b expected 1", bh); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL brk_release: got %b expected 0", busy); end
    cyc(bit_cyc);
  endtask

  task automatic test_overrun();
    logic [9:0] e;
    s_if.m_ready = 1'b0;
    rxq.delete();
    send_frame(8'h55, 1'b1, 1'b0, 0, bm, bl, bh);
    send_frame(8'hAA, 1'b1, 1'b0, 0, bm, bl, bh);
    cyc(bit_cyc);
    checks++; if (s_if.m_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held: got %b expected 1", s_if.m_valid); end
    checks++; if (s_if.m_data !== 8'h55) begin failures++; $display("FAIL ovr_data_kept: got %0h expected 55", s_if.m_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    s_if.m_ready = 1'b1;
    cyc(1);
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_clear: got %b expected 0", s_if.m_valid); end
    pop_word(e);
    checks++; if (e[7:0] !== 8'h55) begin failures++; $display("FAIL ovr_accepted: got %0h expected 55", e[7:0]); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    logic d0, d1, d2;
    set_baud(2'b11);
    s_if.m_ready = 1'b1;
    rxq.delete();
    cyc(8);
    send_frame(8'hC3, 1'b1, 1'b0, 0, bm, bl, bh);
    send_frame(8'h3C, 1'b1, 1'b0, 0, bm, bl, bh);
    cyc(2 * bit_cyc);
    checks++; if (rxq.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", rxq.size()); end
    pop_word(e);
    checks++; if (e !== {2'b00, 8'hC3}) begin failures++; $display("FAIL b2b_first: got %0h expected 0c3", e); end
    pop_word(e);
    checks++; if (e !== {2'b00, 8'h3C}) begin failures++; $display("FAIL b2b_second: got %0h expected 03c", e); end
    fork
      send_frame(8'h96, 1'b1, 1'b0, 0, d0, d1, d2);
      begin cyc(40); b_sel = 2'b00; end
    join
    cyc(2 * bit_cyc);
    pop_word(e);
    checks++; if (e !== {2'b00, 8'h96}) begin failures++; $display("FAIL bsel_midframe: got %0h expected 096", e); end
    set_baud(2'b01);
    cyc(8);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [9:0] e;
    d = 8'h12;
    rxq.delete();
    rx = 1'b0;
    cyc(bit_cyc);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      cyc(bit_cyc);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    rx = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b expected 0", busy); end
    checks++; if (s_if.m_data !== 8'h00) begin failures++; $display("FAIL rm_m_data: got %0h expected 0", s_if.m_data); end
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL rm_m_valid: got %b expected 0", s_if.m_valid); end
    cyc(3);
    rst = 1'b0;
    cyc(bit_cyc);
    send_frame(8'h12, 1'b1, 1'b0, 0, bm, bl, bh);
    cyc(bit_cyc);
    checks++; if (rxq.size() != 1) begin failures++; $display("FAIL rm_count: got %0d expected 1", rxq.size()); end
    pop_word(e);
    checks++; if (e !== {2'b00, 8'h12}) begin failures++; $display("FAIL rm_clean_word: got %0h expected 012", e); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [9:0] e;
    parity_odd = 1'b1;
    rxq.delete();
    send_frame(8'h07, 1'b1, 1'b1, 0, bm, bl, bh);
    cyc(bit_cyc);
    pop_word(e);
    checks++; if (e !== {2'b10, 8'h07}) begin failures++; $display("FAIL par_bad: got %0h expected 207", e); end
    send_frame(8'h07, 1'b1, 1'b0, 0, bm, bl, bh);
    cyc(bit_cyc);
    pop_word(e);
    checks++; if (e !== {2'b00, 8'h07}) begin failures++; $display("FAIL par_good: got %0h expected 007", e); end
    parity_odd = 1'b0;
  endtask
`endif

  initial begin
    s_if.m_ready = 1'b0;
    cyc(2);
    test_pkg();
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
